// File: rtl/gpio_irq_mm.sv
// gpio_irq_mm: memory-mapped GPIO with output polarity, atomic set/clear/toggle,
// synchronised inputs with rise/fall edge capture and a masked level interrupt.
`timescale 1ns/1ps
module gpio_irq_mm #(
    parameter int               N_OUT       = 3,
    parameter int               N_IN        = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_OUT-1:0] OUT_INV     = 3'b111,
    parameter logic [N_OUT-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [N_OUT-1:0] gpio_out,
    input  logic [N_IN-1:0]  gpio_in,
    output logic             irq,
    input  logic             rd_req,
    input  logic [31:0]      rd_addr,
    output logic [31:0]      rd_data,
    output logic             data_valid,
    input  logic             wr_req,
    input  logic [31:0]      wr_addr,
    input  logic [31:0]      wr_data
);
    localparam logic [31:0] A_OUT     = 32'h00;
    localparam logic [31:0] A_IN      = 32'h04;
    localparam logic [31:0] A_IRQ_EN  = 32'h08;
    localparam logic [31:0] A_RISE_EN = 32'h0C;
    localparam logic [31:0] A_FALL_EN = 32'h10;
    localparam logic [31:0] A_STATUS  = 32'h14;
    localparam logic [31:0] A_OUT_SET = 32'h18;
    localparam logic [31:0] A_OUT_CLR = 32'h1C;
    localparam logic [31:0] A_OUT_TGL = 32'h20;

    // Edge capture stays off until the synchroniser has been refilled from reset
    // and prev holds a real sample, so a pin already high at reset is not a rise.
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
    logic [N_IN-1:0]  prev_q;
    logic [ARM_W-1:0] arm_cnt_q;
    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  irq_en_q, irq_en_d;
    logic [N_IN-1:0]  rise_en_q, rise_en_d;
    logic [N_IN-1:0]  fall_en_q, fall_en_d;
    logic [N_IN-1:0]  status_q, status_d;
    logic             irq_q;
    logic [31:0]      rd_data_q;
    logic             data_valid_q;

    logic [N_IN-1:0]  s_in;
    logic [N_IN-1:0]  edge_set;
    logic [N_IN-1:0]  w1c;
    logic             armed;
    logic             rd_hit;
    logic [31:0]      rd_val;
    logic             wr_data_unused;

    assign s_in     = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_cnt_q == ARM_W'(ARM_MAX));
    assign gpio_out = out_q ^ OUT_INV;
    assign irq      = irq_q;
    assign rd_data  = rd_data_q;
    assign data_valid = data_valid_q;
    // Only the low bits of a write are meaningful; the rest are deliberately dropped.
    assign wr_data_unused = ^wr_data;

    // Edge detection and sticky status update; a new edge beats a same-cycle W1C.
    always_comb begin
        edge_set = '0;
        if (armed) begin
            edge_set = (s_in & ~prev_q & rise_en_q) | (~s_in & prev_q & fall_en_q);
        end
        w1c = '0;
        if (wr_req && wr_addr == A_STATUS) begin
            w1c = wr_data[N_IN-1:0];
        end
        status_d = (status_q & ~w1c) | edge_set;
    end

    // Register-file write decode, including the atomic OUT operations.
    always_comb begin
        out_d     = out_q;
        irq_en_d  = irq_en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr_req) begin
            case (wr_addr)
                A_OUT:     out_d     = wr_data[N_OUT-1:0];
                A_OUT_SET: out_d     = out_q | wr_data[N_OUT-1:0];
                A_OUT_CLR: out_d     = out_q & ~wr_data[N_OUT-1:0];
                A_OUT_TGL: out_d     = out_q ^ wr_data[N_OUT-1:0];
                A_IRQ_EN:  irq_en_d  = wr_data[N_IN-1:0];
                A_RISE_EN: rise_en_d = wr_data[N_IN-1:0];
                A_FALL_EN: fall_en_d = wr_data[N_IN-1:0];
                default:   ;
            endcase
        end
    end

    // Read mux on current register values; unmapped offsets do not respond.
    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        case (rd_addr)
            A_OUT, A_OUT_SET, A_OUT_CLR, A_OUT_TGL: rd_val[N_OUT-1:0] = out_q;
            A_IN:      rd_val[N_IN-1:0] = s_in;
            A_IRQ_EN:  rd_val[N_IN-1:0] = irq_en_q;
            A_RISE_EN: rd_val[N_IN-1:0] = rise_en_q;
            A_FALL_EN: rd_val[N_IN-1:0] = fall_en_q;
            A_STATUS:  rd_val[N_IN-1:0] = status_q;
            default:   rd_hit = 1'b0;
        endcase
    end

    // Input synchroniser, previous sample and saturating arm counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= s_in;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + ARM_W'(1);
            end
        end
    end

    // Control/status registers and the registered interrupt line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= OUT_RESET;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            irq_en_q  <= irq_en_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_q     <= |(status_q & irq_en_q);
        end
    end

    // Read response: one-cycle valid pulse, data held until the next mapped read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q    <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_req && rd_hit;
            if (rd_req && rd_hit) begin
                rd_data_q <= rd_val;
            end
        end
    end
endmodule

// File: tb/tb_gpio_irq_mm.sv
// tb_gpio_irq_mm: directed stimulus with a read-response scoreboard for gpio_irq_mm.
`timescale 1ns/1ps
module tb_gpio_irq_mm;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  gpio_out;
    logic [3:0]  gpio_in;
    logic        irq;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        data_valid;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    gpio_irq_mm #(
        .N_OUT(3), .N_IN(4), .SYNC_STAGES(2), .OUT_INV(3'b111), .OUT_RESET(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .data_valid(data_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_req = 1'b0;
        $display("wr  addr=0x%02h data=0x%0h", a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        exp_t x;
        x.addr = a; x.data = e;
        exp_q.push_back(x);
        rd_req = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every response strobe must match the oldest outstanding read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && data_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_valid: got rd_data=0x%0h, required no response", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("rd  addr=0x%02h data=0x%0h exp=0x%0h", e.addr, rd_data, e.data);
                    chk($sformatf("rd_0x%02h", e.addr), rd_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; gpio_in = 4'h0;
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        idle(3);
        chk("rst_gpio_out", {29'd0, gpio_out}, 32'h7);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'h0);
        reset = 1'b0;
        idle(1);

        // Reset defaults
        rd(32'h00, 32'h0);
        rd(32'h08, 32'h0);
        rd(32'h14, 32'h0);
        chk("def_gpio_out", {29'd0, gpio_out}, 32'h7);
        chk("def_irq", {31'd0, irq}, 32'h0);

        // Atomic OUT operations
        wr(32'h00, 32'h5);  rd(32'h00, 32'h5);
        chk("out5_gpio_out", {29'd0, gpio_out}, 32'h2);
        wr(32'h18, 32'h2);  rd(32'h00, 32'h7);
        wr(32'h1C, 32'h1);  rd(32'h1C, 32'h6);
        wr(32'h20, 32'h7);  rd(32'h20, 32'h1);
        chk("tgl_gpio_out", {29'd0, gpio_out}, 32'h6);
        wr(32'h00, 32'hFFFF_FFF9); rd(32'h18, 32'h1);

        // Input sync and rising edge on bit 0
        wr(32'h0C, 32'h1);
        wr(32'h08, 32'h1);
        gpio_in = 4'h1;
        idle(1);
        rd(32'h04, 32'h0);          // sampled after one stage: not yet visible
        rd(32'h04, 32'h1);          // sampled after SYNC_STAGES clocks
        chk("irq_before_status", {31'd0, irq}, 32'h0);
        rd(32'h14, 32'h1);
        chk("irq_after_status", {31'd0, irq}, 32'h1);
        wr(32'h14, 32'h1);
        rd(32'h14, 32'h0);
        chk("irq_after_w1c", {31'd0, irq}, 32'h0);

        // Masked falling edge on bit 1
        wr(32'h08, 32'h0);
        wr(32'h10, 32'h2);
        gpio_in = 4'h3; idle(4);
        gpio_in = 4'h1; idle(4);
        rd(32'h14, 32'h2);
        chk("masked_irq", {31'd0, irq}, 32'h0);
        wr(32'h08, 32'h2);
        chk("unmask_irq_latency", {31'd0, irq}, 32'h0);
        idle(1);
        chk("unmask_irq", {31'd0, irq}, 32'h1);

        // W1C colliding with a new rise on bit 0
        wr(32'h14, 32'h3);
        gpio_in = 4'h0; idle(4);
        gpio_in = 4'h1; idle(4);
        rd(32'h14, 32'h1);
        gpio_in = 4'h0; idle(4);
        rd(32'h14, 32'h1);
        gpio_in = 4'h1;
        idle(2);
        wr(32'h14, 32'h1);          // lands on the edge that captures the rise
        rd(32'h14, 32'h1);

        // Inputs high through reset release must not produce a rise
        gpio_in = 4'hF;
        reset = 1'b1;
        idle(3);
        chk("rst2_rd_data", rd_data, 32'h0);
        chk("rst2_gpio_out", {29'd0, gpio_out}, 32'h7);
        reset = 1'b0;
        wr(32'h0C, 32'hF);
        idle(4);
        rd(32'h14, 32'h0);
        rd(32'h04, 32'hF);
        rd(32'h00, 32'h0);
        gpio_in = 4'hB; idle(4);
        gpio_in = 4'hF; idle(4);
        rd(32'h14, 32'h4);
        chk("arm_irq_masked", {31'd0, irq}, 32'h0);

        // Unmapped read: no response, data held
        rd_req = 1'b1; rd_addr = 32'h24;
        @(negedge clk);
        rd_req = 1'b0;
        $display("rd  addr=0x24 (unmapped)");
        chk("unmapped_data_valid", {31'd0, data_valid}, 32'h0);
        chk("unmapped_rd_data", rd_data, 32'h4);

        // Same-cycle read and write of OUT returns the old value
        exp_q.push_back('{addr: 32'h00, data: 32'h0});
        rd_req = 1'b1; rd_addr = 32'h00;
        wr_req = 1'b1; wr_addr = 32'h00; wr_data = 32'h5;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        $display("rw  addr=0x00 data=0x5");
        rd(32'h00, 32'h5);
        idle(1);

        // Reset during the response cycle drops it immediately
        rd_req = 1'b1; rd_addr = 32'h00;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        chk("midrd_dv_before", {31'd0, data_valid}, 32'h1);
        reset = 1'b1;
        #1;
        $display("rd  addr=0x00 aborted by reset");
        chk("midrd_dv_reset", {31'd0, data_valid}, 32'h0);
        chk("midrd_rd_data", rd_data, 32'h0);
        idle(2);
        reset = 1'b0;
        idle(3);

        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
